// File: rtl/sap2_timing_pkg.sv
// Shared timing constants for the SAP-2 controller-sequencer.
package sap2_timing_pkg;

  localparam int T_STATES    = 18;
  localparam int T_FETCH_LEN = 3;
  localparam int IDX_W       = 5;

  // Binary T-state indices used by the control matrix (T1 is index 0).
  localparam logic [IDX_W-1:0] T1  = 5'd0;
  localparam logic [IDX_W-1:0] T2  = 5'd1;
  localparam logic [IDX_W-1:0] T3  = 5'd2;
  localparam logic [IDX_W-1:0] T4  = 5'd3;
  localparam logic [IDX_W-1:0] T5  = 5'd4;
  localparam logic [IDX_W-1:0] T6  = 5'd5;
  localparam logic [IDX_W-1:0] T7  = 5'd6;
  localparam logic [IDX_W-1:0] T8  = 5'd7;
  localparam logic [IDX_W-1:0] T9  = 5'd8;
  localparam logic [IDX_W-1:0] T10 = 5'd9;
  localparam logic [IDX_W-1:0] T11 = 5'd10;
  localparam logic [IDX_W-1:0] T12 = 5'd11;
  localparam logic [IDX_W-1:0] T13 = 5'd12;
  localparam logic [IDX_W-1:0] T14 = 5'd13;
  localparam logic [IDX_W-1:0] T15 = 5'd14;
  localparam logic [IDX_W-1:0] T16 = 5'd15;
  localparam logic [IDX_W-1:0] T17 = 5'd16;
  localparam logic [IDX_W-1:0] T18 = 5'd17;

  typedef enum logic {
    MODE_RUN    = 1'b0,
    MODE_HALTED = 1'b1
  } mode_e;

endpackage

// File: rtl/onehot_to_index.sv
// One-hot to binary encoder; output is only meaningful for one-hot input.
module onehot_to_index
  import sap2_timing_pkg::*;
#(
  parameter int N = T_STATES
) (
  input  logic [N-1:0]     iOnehot,
  output logic [IDX_W-1:0] oIdx
);

  // OR together the indices of all set bits.
  always_comb begin
    oIdx = '0;
    for (int i = 0; i < N; i++) begin
      if (iOnehot[i]) oIdx = oIdx | IDX_W'(i);
    end
  end

endmodule

// File: rtl/tstate_ring_counter.sv
// SAP-2 T-state ring counter: one-hot timing states advanced on the
// falling clock edge so control words settle before the rising edge.
module tstate_ring_counter
  import sap2_timing_pkg::*;
#(
  parameter int STATES    = T_STATES,
  parameter int FETCH_LEN = T_FETCH_LEN,
  parameter int CNT_W     = 16
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iEnable,
  input  logic              iEndCycle,
  input  logic              iHalt,
  output logic [STATES-1:0] oT,
  output logic [IDX_W-1:0]  oStateIdx,
  output logic              oFetch,
  output logic              oWrap,
  output logic              oHalted,
  output logic [CNT_W-1:0]  oCycles
);

  localparam logic [STATES-1:0] T_FIRST = STATES'(1);

  mode_e             mode_q, mode_d;
  logic [STATES-1:0] t_q, t_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wrap_q, wrap_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic              t_onehot;
  logic [IDX_W-1:0]  enc_idx;

  // Guards against a corrupted ring (e.g. X-init or upset).
  assign t_onehot = (t_q != '0) && ((t_q & (t_q - STATES'(1))) == '0);

  // Next-state selection in priority order: reset, halted, halt, enable,
  // ring repair, end of cycle / last state, shift.
  always_comb begin
    mode_d = mode_q;
    t_d    = t_q;
    idx_d  = idx_q;
    wrap_d = 1'b0;
    cyc_d  = cyc_q;
    if (iReset) begin
      mode_d = MODE_RUN;
      t_d    = T_FIRST;
      idx_d  = T1;
      cyc_d  = '0;
    end else if (mode_q == MODE_HALTED) begin
      mode_d = MODE_HALTED;
    end else if (iHalt) begin
      mode_d = MODE_HALTED;
    end else if (!iEnable) begin
      mode_d = MODE_RUN;
    end else if (!t_onehot) begin
      t_d   = T_FIRST;
      idx_d = T1;
    end else if (iEndCycle || t_q[STATES-1]) begin
      t_d    = T_FIRST;
      idx_d  = T1;
      wrap_d = 1'b1;
      cyc_d  = cyc_q + CNT_W'(1);
    end else begin
      t_d   = t_q << 1;
      idx_d = idx_q + IDX_W'(1);
    end
  end

  // All state updates on the falling edge, synchronous reset.
  always_ff @(negedge iClk) begin
    mode_q <= mode_d;
    t_q    <= t_d;
    idx_q  <= idx_d;
    wrap_q <= wrap_d;
    cyc_q  <= cyc_d;
  end

  onehot_to_index #(.N(STATES)) u_enc (
    .iOnehot (t_q),
    .oIdx    (enc_idx)
  );

  // Registered index must always agree with the one-hot vector.
  a_idx_match : assert property (@(negedge iClk) disable iff (iReset)
    t_onehot |-> (idx_q == enc_idx));

  assign oT        = t_q;
  assign oStateIdx = idx_q;
  assign oFetch    = |t_q[FETCH_LEN-1:0];
  assign oWrap     = wrap_q;
  assign oHalted   = (mode_q == MODE_HALTED);
  assign oCycles   = cyc_q;

endmodule

// File: tb/tb_tstate_ring_counter.sv
// Directed plus randomized bench for tstate_ring_counter with a
// position/counter reference model.
module tb_tstate_ring_counter;

  localparam int STATES = 18;
  localparam int FLEN   = 3;
  localparam int CNT_W  = 16;

  logic              iClk = 1'b1;
  logic              iReset = 1'b0, iEnable = 1'b0, iEndCycle = 1'b0, iHalt = 1'b0;
  logic [STATES-1:0] oT;
  logic [4:0]        oStateIdx;
  logic              oFetch, oWrap, oHalted;
  logic [CNT_W-1:0]  oCycles;

  int nchk = 0;
  int nerr = 0;

  // reference model: current T position, halted flag, wrap pulse, cycle count
  int m_pos = 0;
  bit m_halted = 0;
  bit m_wrap = 0;
  int m_cnt = 0;

  tstate_ring_counter #(.STATES(STATES), .FETCH_LEN(FLEN), .CNT_W(CNT_W)) dut (
    .iClk      (iClk),
    .iReset    (iReset),
    .iEnable   (iEnable),
    .iEndCycle (iEndCycle),
    .iHalt     (iHalt),
    .oT        (oT),
    .oStateIdx (oStateIdx),
    .oFetch    (oFetch),
    .oWrap     (oWrap),
    .oHalted   (oHalted),
    .oCycles   (oCycles)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [STATES-1:0] exp_t;
    exp_t = '0;
    exp_t[m_pos] = 1'b1;
    check({tag, ".oT"},      64'(oT),        64'(exp_t));
    check({tag, ".idx"},     64'(oStateIdx), 64'(m_pos));
    check({tag, ".fetch"},   64'(oFetch),    64'(m_pos < FLEN));
    check({tag, ".wrap"},    64'(oWrap),     64'(m_wrap));
    check({tag, ".halted"},  64'(oHalted),   64'(m_halted));
    check({tag, ".cycles"},  64'(oCycles),   64'(m_cnt));
  endtask

  function automatic void model_step(bit rst, bit en, bit ec, bit hlt);
    m_wrap = 0;
    if (rst) begin
      m_pos = 0; m_halted = 0; m_cnt = 0;
    end else if (m_halted) begin
    end else if (hlt) begin
      m_halted = 1;
    end else if (!en) begin
    end else if (ec || m_pos == STATES - 1) begin
      m_pos = 0; m_wrap = 1; m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end else begin
      m_pos = m_pos + 1;
    end
  endfunction

  // Inputs change just after a rising edge; outputs are sampled 1 ns after
  // the following rising edge, well away from the active falling edge.
  task automatic step(input bit rst, input bit en, input bit ec, input bit hlt, input string tag);
    iReset = rst; iEnable = en; iEndCycle = ec; iHalt = hlt;
    @(negedge iClk);
    model_step(rst, en, ec, hlt);
    @(posedge iClk);
    #1;
    check_all(tag);
  endtask

  initial begin
    #1;
    // reset
    step(1, 0, 0, 0, "reset");
    // full ring walk and wrap
    for (int i = 0; i < STATES; i++) step(0, 1, 0, 0, "walk");
    check("walk_cnt", 64'(oCycles), 64'd1);
    // early end at T5
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, "to_t5");
    check("at_t5", 64'(oStateIdx), 64'd4);
    step(0, 1, 1, 0, "endcyc");
    step(0, 1, 0, 0, "after_end");
    // enable hold at T7
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, "to_t7");
    check("at_t7", 64'(oT), 64'h40);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "hold");
    step(0, 1, 0, 0, "reenable");
    // halt with end-cycle at T4
    step(0, 1, 1, 0, "restart");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, "to_t4");
    step(0, 1, 1, 1, "halt_end");
    check("halt_t4", 64'(oT), 64'h8);
    for (int i = 0; i < 10; i++) step(0, i % 2, (i / 2) % 2, i % 3 == 0, "halted");
    step(1, 1, 0, 0, "unhalt");
    // one-state cycle: end while at T1
    step(0, 1, 1, 0, "t1_end");
    // reset mid-cycle at T12 with end-cycle
    for (int i = 0; i < 11; i++) step(0, 1, 0, 0, "to_t12");
    check("at_t12", 64'(oStateIdx), 64'd11);
    step(1, 1, 1, 0, "rst_t12");
    step(0, 1, 0, 0, "after_rst");
    // ring repair from a corrupted vector
    force dut.t_q = 18'h00003;
    #1 release dut.t_q;
    iReset = 0; iEnable = 1; iEndCycle = 0; iHalt = 0;
    @(negedge iClk);
    m_pos = 0; m_wrap = 0;
    @(posedge iClk);
    #1;
    check("repair.oT", 64'(oT), 64'h1);
    check("repair.idx", 64'(oStateIdx), 64'd0);
    check("repair.wrap", 64'(oWrap), 64'd0);
    check("repair.cycles", 64'(oCycles), 64'(m_cnt));
    step(0, 1, 0, 0, "post_repair");
    // counter rollover
    force dut.cyc_q = 16'hFFFF;
    #1 release dut.cyc_q;
    m_cnt = 'hFFFF;
    step(0, 1, 1, 0, "rollover");
    check("rollover0", 64'(oCycles), 64'd0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 48) == 0, ($urandom % 4) != 0, ($urandom % 8) == 0,
           ($urandom % 60) == 0, "rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
